irq_request_ctrl: RTL and testbench



---
 rtl/irq_request_ctrl.sv | 129 ++++++++++++
 tb/tb_irq_request_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_ctrl.sv
// irq_request_ctrl: 4-source interrupt initiator for the CP0 break/code handshake.
// Optional nesting (preemption by strictly higher priority) enabled by macro IRQ_NESTED_EN.
`default_nettype none

module irq_request_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NSRC        = 4
) (
  input  logic       in_clk,
  input  logic       in_RST,
  input  logic [3:0] in_irq,
  input  logic       in_IE,
  input  logic [3:0] in_INM,
  input  logic       in_ack,
  input  logic       in_eret,
  output logic       out_BK,
  output logic [1:0] out_code,
  output logic [3:0] out_pending,
  output logic [3:0] out_ISR
);

  generate
    if (NSRC != 4) begin : g_nsrc_check
      $error("irq_request_ctrl: NSRC must be 4 to match the 2-bit cause code");
    end
    if (SYNC_STAGES < 2) begin : g_sync_check
      $error("irq_request_ctrl: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t                        state;
  logic [SYNC_STAGES-1:0][3:0]   sync_q;
  logic [3:0]                    sync_prev;
  logic [3:0]                    pending;
  logic [3:0]                    isr;

  logic [3:0] rise;
  logic [3:0] isr_lowest;
  logic [3:0] allowed;
  logic [3:0] eligible;
  logic [1:0] winner;
  logic [3:0] code_onehot;
  logic [3:0] ack_clr;
  logic [3:0] isr_after_eret;
  logic       ack_take;

  always_ff @(posedge in_clk or negedge in_RST) begin
    if (!in_RST) begin
      sync_q    <= '0;
      sync_prev <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_irq};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise       = sync_q[SYNC_STAGES-1] & ~sync_prev;
  // Isolate the highest-priority (lowest-index) in-service bit.
  assign isr_lowest = isr & (~isr + 4'd1);

`ifdef IRQ_NESTED_EN
  // Indices strictly below the active level; all ones when nothing is in service.
  assign allowed = isr_lowest - 4'd1;
`else
  assign allowed = (isr == 4'd0) ? 4'b1111 : 4'b0000;
`endif

  assign eligible = pending & in_INM & {4{in_IE}} & allowed;

  always_comb begin
    winner = 2'd0;
    if (eligible[0])      winner = 2'd0;
    else if (eligible[1]) winner = 2'd1;
    else if (eligible[2]) winner = 2'd2;
    else if (eligible[3]) winner = 2'd3;
  end

  assign code_onehot    = 4'b0001 << out_code;
  assign ack_take       = (state == REQ) && in_ack;
  assign ack_clr        = ack_take ? code_onehot : 4'b0000;
  assign isr_after_eret = in_eret ? (isr & ~isr_lowest) : isr;

  always_ff @(posedge in_clk or negedge in_RST) begin
    if (!in_RST) begin
      state    <= IDLE;
      out_BK   <= 1'b0;
      out_code <= 2'd0;
      pending  <= 4'd0;
      isr      <= 4'd0;
    end else begin
      // A fresh edge wins over the ack clear; eret is applied before the ack set.
      pending <= (pending & ~ack_clr) | rise;
      isr     <= isr_after_eret | ack_clr;
      case (state)
        IDLE: begin
          if (|eligible) begin
            out_code <= winner;
            out_BK   <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (in_ack) begin
            out_BK <= 1'b0;
            state  <= IDLE;
          end else if (!in_IE || !in_INM[out_code]) begin
            out_BK <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          out_BK <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign out_pending = pending;
  assign out_ISR     = isr;

endmodule

`default_nettype wire

// File: tb/tb_irq_request_ctrl.sv
// Testbench for irq_request_ctrl: directed table, hand sequences and randomized model check.
`default_nettype none

module tb_irq_request_ctrl;

  localparam int S = 2;
`ifdef IRQ_NESTED_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  logic       in_clk = 1'b0;
  logic       in_RST = 1'b0;
  logic [3:0] in_irq = '0;
  logic       in_IE = 1'b1;
  logic [3:0] in_INM = 4'hF;
  logic       in_ack = 1'b0;
  logic       in_eret = 1'b0;
  logic       out_BK;
  logic [1:0] out_code;
  logic [3:0] out_pending;
  logic [3:0] out_ISR;

  irq_request_ctrl #(.SYNC_STAGES(S), .NSRC(4)) dut (
    .in_clk(in_clk), .in_RST(in_RST), .in_irq(in_irq), .in_IE(in_IE),
    .in_INM(in_INM), .in_ack(in_ack), .in_eret(in_eret), .out_BK(out_BK),
    .out_code(out_code), .out_pending(out_pending), .out_ISR(out_ISR)
  );

  always #5 in_clk = ~in_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw-input history, pending/in-service sets, outstanding request.
  logic [3:0] hist [0:S+1];
  logic [3:0] m_pend, m_isr;
  logic       m_busy;
  int         m_code;

  task automatic model_reset();
    m_pend = '0; m_isr = '0; m_busy = 1'b0; m_code = 0;
    for (int j = 0; j <= S + 1; j++) hist[j] = '0;
  endtask

  task automatic model_step();
    logic [3:0] edge_v, elig;
    int  low;
    bit  ack_fire, wdraw, found;
    for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = in_irq;
    edge_v = hist[S] & ~hist[S+1];
    low = 4;
    for (int i = 3; i >= 0; i--) if (m_isr[i]) low = i;
    for (int i = 0; i < 4; i++)
      elig[i] = m_pend[i] && in_INM[i] && in_IE && (NESTED ? (i < low) : (m_isr == 4'd0));
    ack_fire = m_busy && in_ack;
    wdraw    = m_busy && !in_ack && (!in_IE || !in_INM[m_code]);
    if (in_eret && low < 4) m_isr[low] = 1'b0;
    if (ack_fire) begin
      m_isr[m_code]  = 1'b1;
      m_pend[m_code] = 1'b0;
    end
    m_pend = m_pend | edge_v;
    if (!m_busy) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++)
        if (elig[i] && !found) begin
          found = 1'b1; m_busy = 1'b1; m_code = i;
        end
    end else if (ack_fire || wdraw) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge in_clk);
    #1;
    check("model_BK", out_BK, m_busy);
    check("model_pending", out_pending, m_pend);
    check("model_ISR", out_ISR, m_isr);
    if (m_busy) check("model_code", out_code, m_code);
  endtask

  task automatic wait_bk(input int budget);
    int n = 0;
    while (!out_BK && n < budget) begin
      tick();
      n++;
    end
    check("wait_bk_timeout", out_BK, 1'b1);
  endtask

  task automatic async_reset();
    #2;
    in_RST = 1'b0;
    #1;
    check("areset_BK", out_BK, 1'b0);
    check("areset_code", out_code, 2'd0);
    check("areset_pending", out_pending, 4'd0);
    check("areset_ISR", out_ISR, 4'd0);
    model_reset();
    @(posedge in_clk);
    #1;
    in_RST = 1'b1;
  endtask

  typedef struct {
    logic [3:0] irq;
    logic       ack;
    logic       eret;
    logic       bk;
    logic [1:0] code;
    logic [3:0] pend;
    logic [3:0] isr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Basic request on source 2: BK rises SYNC_STAGES+2 edges after the raw edge.
    vecs[0] = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
    vecs[1] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
    vecs[2] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0};
    vecs[3] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0};
    vecs[4] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0};
    vecs[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h4};
    vecs[6] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0};
    vecs[7] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};

    model_reset();
    #1;
    check("reset_BK", out_BK, 1'b0);
    check("reset_code", out_code, 2'd0);
    check("reset_pending", out_pending, 4'd0);
    check("reset_ISR", out_ISR, 4'd0);
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    in_RST = 1'b1;

    for (int i = 0; i < 8; i++) begin
      in_irq = vecs[i].irq; in_ack = vecs[i].ack; in_eret = vecs[i].eret;
      tick();
      check($sformatf("vec%0d_BK", i), out_BK, vecs[i].bk);
      if (vecs[i].bk) check($sformatf("vec%0d_code", i), out_code, vecs[i].code);
      check($sformatf("vec%0d_pending", i), out_pending, vecs[i].pend);
      check($sformatf("vec%0d_ISR", i), out_ISR, vecs[i].isr);
    end
    in_ack = 1'b0; in_eret = 1'b0;

    // Priority among simultaneous edges, then code stability in REQ.
    in_irq = 4'b1010; tick();
    in_irq = 4'b0000; tick();
    wait_bk(8);
    check("prio_code", out_code, 2'd1);
    in_irq = 4'b0001; tick();
    in_irq = 4'b0000; tick(); tick(); tick();
    check("stable_BK", out_BK, 1'b1);
    check("stable_code", out_code, 2'd1);
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    check("ack_ISR", out_ISR, 4'b0010);
`ifdef IRQ_NESTED_EN
    wait_bk(4);
    check("nest_code", out_code, 2'd0);
    in_ack = 1'b1; in_eret = 1'b1; tick();
    in_ack = 1'b0; in_eret = 1'b0;
    check("ack_eret_ISR", out_ISR, 4'b0001);
`else
    tick();
    check("no_preempt_BK", out_BK, 1'b0);
    in_eret = 1'b1; tick(); in_eret = 1'b0;
    wait_bk(4);
    check("after_eret_code", out_code, 2'd0);
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    check("ack0_ISR", out_ISR, 4'b0001);
`endif

    // New edge on source 0 in the same cycle as its ack.
    in_INM = 4'b0001;
    in_eret = 1'b1; tick(); in_eret = 1'b0;
    in_irq = 4'b0001; tick();
    in_irq = 4'b0000; tick();
    wait_bk(6);
    check("src0_code", out_code, 2'd0);
    in_irq = 4'b0001; tick();
    in_irq = 4'b0000; tick();
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    check("edge_ack_pend0", out_pending[0], 1'b1);
    check("edge_ack_ISR", out_ISR, 4'b0001);

    // Withdraw on IE drop, re-request on restore.
    in_eret = 1'b1; tick(); in_eret = 1'b0;
    wait_bk(4);
    in_IE = 1'b0; tick();
    check("withdraw_BK", out_BK, 1'b0);
    check("withdraw_pend0", out_pending[0], 1'b1);
    in_IE = 1'b1; tick();
    check("rerequest_BK", out_BK, 1'b1);

    async_reset();
    in_INM = 4'hF;

    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) in_irq[b] = ~in_irq[b];
      in_IE   = ($urandom_range(15) != 0);
      if ($urandom_range(31) == 0) in_INM = 4'($urandom);
      in_ack  = ($urandom_range(2) == 0);
      in_eret = ($urandom_range(5) == 0);
      tick();
      if ($urandom_range(499) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
